enc_prio_disp: RTL

- Parametrised priority encoder with registered, debounced output and on-board display drive.
- Samples an IN_W-bit switch vector and finds the highest set bit.
- Commits the result only after it has been stable for STABLE_CYC cycles.
- Counts committed valid-index changes and drives four 7-segment digits: index, valid flag, event count low/high nibble.
- Sits between board switches and the segment displays.

---
 rtl/enc_prio_disp_if.sv | 26 ++
 rtl/enc_prio_disp.sv | 103 ++++++++++
 2 files changed

// File: rtl/enc_prio_disp_if.sv
// Switch-to-display bus for enc_prio_disp: raw requests and controls in,
// committed index/valid/count and four 7-segment digits out.
interface enc_prio_disp_if #(
    parameter int unsigned IN_W = 8
);
    logic [IN_W-1:0] I;
    logic            hold;
    logic            clr_cnt;
    logic [3:0]      idx;
    logic            valid;
    logic [7:0]      evt_cnt;
    logic [6:0]      h0;
    logic [6:0]      h1;
    logic [6:0]      h2;
    logic [6:0]      h3;

    modport master (
        output I, hold, clr_cnt,
        input  idx, valid, evt_cnt, h0, h1, h2, h3
    );

    modport slave (
        input  I, hold, clr_cnt,
        output idx, valid, evt_cnt, h0, h1, h2, h3
    );
endinterface

// File: rtl/enc_prio_disp.sv
// Debounced priority encoder with commit counter and 7-segment drive.
// Define ENC_PRIO_DISP_BLANK_EN to blank the index digit while nothing is valid.
module enc_prio_disp #(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic           clk,
    input  logic           rst,
    enc_prio_disp_if.slave bus
);
    localparam logic [15:0] LastCnt = 16'(STABLE_CYC - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [IN_W-1:0] r_in_q;
    logic [4:0]      r_pend;
    logic [15:0]     r_st_cnt;
    logic [3:0]      r_idx;
    logic            r_valid;
    logic [7:0]      r_evt_cnt;

    logic            w_cv;
    logic [3:0]      w_ci;
    logic [4:0]      w_cand;
    logic            w_stable;
    logic            w_commit;

    // Ascending scan: the last set bit seen is the highest-priority one.
    always_comb begin
        w_ci = 4'd0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (r_in_q[i]) w_ci = 4'(i);
        end
        w_cv = |r_in_q;
    end

    assign w_cand   = {w_cv, w_ci};
    assign w_stable = (w_cand == r_pend) && (r_st_cnt == LastCnt);
    assign w_commit = w_stable && (r_pend != {r_valid, r_idx}) && !bus.hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in_q    <= '0;
            r_pend    <= '0;
            r_st_cnt  <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_evt_cnt <= '0;
        end else begin
            r_in_q <= bus.I;
            if (w_cand != r_pend) begin
                r_pend   <= w_cand;
                r_st_cnt <= '0;
            end else if (r_st_cnt < LastCnt) begin
                r_st_cnt <= r_st_cnt + 16'd1;
            end
            if (w_commit) begin
                r_valid <= r_pend[4];
                r_idx   <= r_pend[3:0];
            end
            if (bus.clr_cnt) begin
                r_evt_cnt <= '0;
            end else if (w_commit && r_pend[4]) begin
                r_evt_cnt <= r_evt_cnt + 8'd1;
            end
        end
    end

    assign bus.idx     = r_idx;
    assign bus.valid   = r_valid;
    assign bus.evt_cnt = r_evt_cnt;
`ifdef ENC_PRIO_DISP_BLANK_EN
    assign bus.h0      = r_valid ? hex7(r_idx) : 7'b1111111;
`else
    assign bus.h0      = hex7(r_idx);
`endif
    assign bus.h1      = hex7({3'b000, r_valid});
    assign bus.h2      = hex7(r_evt_cnt[3:0]);
    assign bus.h3      = hex7(r_evt_cnt[7:4]);
endmodule
